// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: multiplies each accepted sample by a phase-locked
// reference sine, integrates over one symbol and emits a hard/soft decision.
module bpsk_demodulator #(
  parameter int DATA_WIDTH        = 8,
  parameter int SINE_RESOLUTION   = 32,
  parameter int CYCLES_PER_SYMBOL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sync,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  bit_ready,
  output logic                  bit_valid,
  output logic                  bit_out,
  output logic [DATA_WIDTH-1:0] soft_out,
  output logic                  overrun,
  output logic                  locked
);

  localparam int PERIOD_LEN = 2 * SINE_RESOLUTION;
  localparam int SYMBOL_LEN = PERIOD_LEN * CYCLES_PER_SYMBOL;
  localparam int SYM_W      = $clog2(SYMBOL_LEN);
  localparam int PROD_W     = 2 * DATA_WIDTH;
  localparam int ACC_W      = PROD_W + SYM_W;
  localparam int PH_W       = $clog2(PERIOD_LEN);
  localparam int PER_W      = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD_LEN - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CYCLES_PER_SYMBOL - 1);
  localparam longint PI_Q30 = 64'sd3373259426;

  // Elaboration-time sine table in Q30 fixed point (Taylor series on the
  // folded angle <= pi/2), rounded half-up to the sample amplitude.
  function automatic logic [SINE_RESOLUTION*DATA_WIDTH-1:0] build_lut();
    logic [SINE_RESOLUTION*DATA_WIDTH-1:0] lut;
    longint x, x2, term, s, amp;
    int     k2;
    lut = '0;
    amp = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    for (int k = 0; k < SINE_RESOLUTION; k++) begin
      k2   = (2 * k > SINE_RESOLUTION) ? SINE_RESOLUTION - k : k;
      x    = (PI_Q30 * k2) / SINE_RESOLUTION;
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      for (int n = 1; n <= 8; n++) begin
        term = -(((term * x2) >>> 30) / ((2 * n) * (2 * n + 1)));
        s    = s + term;
      end
      lut[k*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'((amp * s + (64'sd1 <<< 29) + 64'sd4096) >>> 30);
    end
    return lut;
  endfunction

  localparam logic [SINE_RESOLUTION*DATA_WIDTH-1:0] SINE_LUT = build_lut();

  // Full-period reference: second half is the negated first half.
  logic signed [DATA_WIDTH-1:0] sine_rom [PERIOD_LEN];
  for (genvar k = 0; k < SINE_RESOLUTION; k++) begin : g_rom
    assign sine_rom[k]                   = SINE_LUT[k*DATA_WIDTH +: DATA_WIDTH];
    assign sine_rom[k + SINE_RESOLUTION] = -SINE_LUT[k*DATA_WIDTH +: DATA_WIDTH];
  end

  typedef enum logic {IDLE = 1'b0, INTEGRATE = 1'b1} state_t;
  state_t state;

  logic [PH_W-1:0]          phase, phase_used, phase_next;
  logic [PER_W-1:0]         period, period_used, period_next;
  logic                     accept, abort, last;
  logic signed [PROD_W-1:0] product, prod_q;
  logic                     prod_valid, prod_last;
  logic [ACC_W-1:0]         acc, acc_base, dec_sum;
  logic                     acc_done, dec_valid;

  always_comb begin
    accept      = sample_valid && enable && (state == INTEGRATE || sync);
    phase_used  = sync ? '0 : phase;
    period_used = sync ? '0 : period;
    last        = (phase_used == PH_LAST) && (period_used == PER_LAST);
    phase_next  = (phase_used == PH_LAST) ? '0 : phase_used + PH_W'(1);
    period_next = period_used;
    if (phase_used == PH_LAST)
      period_next = (period_used == PER_LAST) ? '0 : period_used + PER_W'(1);
    // A sync that lands exactly on a symbol boundary is not a restart.
    abort    = (state == INTEGRATE) &&
               (!enable || (sample_valid && sync && (phase != '0 || period != '0)));
    acc_base = acc_done ? '0 : acc;
    product  = PROD_W'($signed(sample_in)) * PROD_W'(sine_rom[phase_used]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      locked     <= 1'b0;
      phase      <= '0;
      period     <= '0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      acc        <= '0;
      acc_done   <= 1'b0;
      dec_sum    <= '0;
      dec_valid  <= 1'b0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      soft_out   <= '0;
      overrun    <= 1'b0;
    end else begin
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
        phase  <= '0;
        period <= '0;
      end else if (accept) begin
        state  <= INTEGRATE;
        locked <= 1'b1;
        phase  <= phase_next;
        period <= period_next;
      end

      prod_valid <= accept;
      if (accept) begin
        prod_q    <= product;
        prod_last <= last;
      end

      // acc_done marks acc as a completed symbol sum for exactly one cycle.
      if (abort) begin
        acc      <= '0;
        acc_done <= 1'b0;
      end else if (prod_valid) begin
        acc      <= acc_base + {{SYM_W{prod_q[PROD_W-1]}}, prod_q};
        acc_done <= prod_last;
      end else if (acc_done) begin
        acc      <= '0;
        acc_done <= 1'b0;
      end

      dec_valid <= acc_done;
      if (acc_done)
        dec_sum <= acc;

      // Valid/ready: outputs frozen while bit_valid && !bit_ready; a transfer
      // happens on an edge with both high; a decision arriving while frozen is lost.
      if (dec_valid) begin
        if (bit_valid && !bit_ready) begin
          overrun <= 1'b1;
        end else begin
          bit_valid <= 1'b1;
          bit_out   <= dec_sum[ACC_W-1];
          soft_out  <= dec_sum[ACC_W-1 -: DATA_WIDTH];
        end
      end else if (bit_valid && bit_ready) begin
        bit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Bench for bpsk_demodulator (8-bit samples, 4-entry half-period table, one
// carrier period per symbol): fixed vectors, corner sequences, random symbols.
module tb_bpsk_demodulator;

  localparam int DW  = 8;
  localparam int SR  = 4;
  localparam int CPS = 1;
  localparam int SL  = 2 * SR * CPS;

  logic          clk = 1'b0;
  logic          rst_n, enable, sync, sample_valid, bit_ready;
  logic [DW-1:0] sample_in;
  logic          bit_valid, bit_out, overrun, locked;
  logic [DW-1:0] soft_out;

  bpsk_demodulator #(
    .DATA_WIDTH(DW), .SINE_RESOLUTION(SR), .CYCLES_PER_SYMBOL(CPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync),
    .sample_valid(sample_valid), .sample_in(sample_in), .bit_ready(bit_ready),
    .bit_valid(bit_valid), .bit_out(bit_out), .soft_out(soft_out),
    .overrun(overrun), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*SL-1:0] samples;
    logic            exp_bit;
    logic [DW-1:0]   exp_soft;
  } vec_t;

  vec_t          vecs [6];
  logic [DW:0]   exp_q [$];
  int            pass_cnt = 0, total_cnt = 0;
  int            xfer_cnt = 0;
  logic          last_bit;
  logic [DW-1:0] last_soft;
  logic          sb_on = 1'b0, ready_rand = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(int a0, int a1, int a2, int a3, int a4, int a5,
                              int a6, int a7, int b, int sf);
    vec_t v;
    v.samples  = {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    v.exp_bit  = 1'(b);
    v.exp_soft = 8'(sf);
    return v;
  endfunction

  // Reference model: correlation against round(127*sin(pi*p/SR)) over one symbol.
  function automatic longint ref_carrier(int p);
    real a;
    a = 127.0 * $sin(3.14159265358979 * (p % SR) / SR);
    return (p >= SR) ? -longint'($rtoi(a + 0.5)) : longint'($rtoi(a + 0.5));
  endfunction

  function automatic logic [DW:0] model_entry(logic [8*SL-1:0] smp);
    longint sum = 0;
    for (int i = 0; i < SL; i++)
      sum += longint'($signed(smp[i*8 +: 8])) * ref_carrier(i % (2 * SR));
    return {sum < 0, 8'(sum >>> 11)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_sample(input logic s, input logic [DW-1:0] v);
    sync = s; sample_valid = 1'b1; sample_in = v;
    @(posedge clk); #1;
    sync = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic send_symbol(input logic [8*SL-1:0] smp, input int gmin, input int gmax);
    for (int i = 0; i < SL; i++) begin
      put_sample(i == 0, smp[i*8 +: 8]);
      if (i < SL - 1 && gmax > 0) idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic wait_decision(output int lat);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (bit_valid) begin lat = n; break; end
    end
  endtask

  // Monitor: counts transfers, checks hold stability, drains the scoreboard.
  initial begin
    logic          prev_stall = 1'b0, prev_bit = 1'b0;
    logic [DW-1:0] prev_soft = '0;
    logic [DW:0]   e;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall)
        check("hold_stable", longint'({bit_valid, bit_out, soft_out}),
              longint'({1'b1, prev_bit, prev_soft}));
      if (rst_n && bit_valid && bit_ready) begin
        xfer_cnt++;
        last_bit  = bit_out;
        last_soft = soft_out;
        if (sb_on) begin
          check("sb_pending", longint'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_bit", longint'(bit_out), longint'(e[DW]));
            check("sb_soft", longint'($signed(soft_out)), longint'($signed(e[DW-1:0])));
          end
        end
      end
      prev_stall = rst_n && bit_valid && !bit_ready;
      prev_bit   = bit_out;
      prev_soft  = soft_out;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_rand) bit_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, lat, seen;
    logic [8*SL-1:0] smp;

    vecs[0] = mk(0, 90, 127, 90, 0, -90, -127, -90, 0, 31);
    vecs[1] = mk(0, -90, -127, -90, 0, 90, 127, 90, 1, -32);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(127, 127, 127, 127, -128, -128, -128, -128, 0, 38);
    vecs[4] = mk(0, -1, -1, -1, 0, 1, 1, 1, 1, -1);
    vecs[5] = mk(50, 50, 50, 50, 50, 50, 50, 50, 0, 0);

    rst_n = 1'b0; enable = 1'b0; sync = 1'b0; sample_valid = 1'b0;
    sample_in = '0; bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_soft_out", soft_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1; enable = 1'b1; bit_ready = 1'b1;
    idle(1);

    // Table vectors, each followed by a latency/decision check.
    for (int i = 0; i < 6; i++) begin
      send_symbol(vecs[i].samples, 0, 0);
      wait_decision(lat);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_bit", i), bit_out, vecs[i].exp_bit);
      check($sformatf("vec%0d_soft", i), $signed(soft_out), $signed(vecs[i].exp_soft));
    end
    idle(2);
    check("locked_integrate", locked, 1);
    check("no_overrun_yet", overrun, 0);

    // Back-to-back symbols: accumulator must restart with no gap.
    sb_on = 1'b1;
    exp_q.push_back({vecs[3].exp_bit, vecs[3].exp_soft});
    exp_q.push_back({vecs[4].exp_bit, vecs[4].exp_soft});
    send_symbol(vecs[3].samples, 0, 0);
    send_symbol(vecs[4].samples, 0, 0);
    idle(6);
    check("b2b_drained", exp_q.size(), 0);
    sb_on = 1'b0;

    // Gaps of 1-3 idle cycles between samples leave the result unchanged.
    send_symbol(vecs[0].samples, 1, 3);
    wait_decision(lat);
    check("gap_latency", lat, 3);
    check("gap_bit", bit_out, 0);
    check("gap_soft", $signed(soft_out), 31);
    send_symbol(vecs[4].samples, 1, 3);
    wait_decision(lat);
    check("gap_small_bit", bit_out, 1);
    check("gap_small_soft", $signed(soft_out), -1);
    idle(2);

    // sync after 5 samples restarts the symbol; only one decision results.
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++) put_sample(i == 0, vecs[1].samples[i*8 +: 8]);
    send_symbol(vecs[0].samples, 0, 0);
    idle(8);
    check("resync_count", xfer_cnt - x0, 1);
    check("resync_bit", last_bit, 0);
    check("resync_soft", $signed(last_soft), 31);

    // enable low mid-symbol discards the partial symbol.
    x0 = xfer_cnt;
    for (int i = 0; i < 4; i++) put_sample(i == 0, vecs[1].samples[i*8 +: 8]);
    enable = 1'b0;
    idle(1);
    check("disable_locked", locked, 0);
    enable = 1'b1;
    idle(4);
    check("disable_no_decision", xfer_cnt - x0, 0);
    send_symbol(vecs[0].samples, 0, 0);
    idle(8);
    check("disable_count", xfer_cnt - x0, 1);
    check("disable_bit", last_bit, 0);

    // Two symbols with bit_ready low: first held, second dropped, overrun set.
    bit_ready = 1'b0;
    x0 = xfer_cnt;
    send_symbol(vecs[0].samples, 0, 0);
    send_symbol(vecs[1].samples, 0, 0);
    idle(6);
    check("ovr_valid", bit_valid, 1);
    check("ovr_bit", bit_out, 0);
    check("ovr_soft", $signed(soft_out), 31);
    check("ovr_flag", overrun, 1);
    bit_ready = 1'b1;
    idle(5);
    check("ovr_xfer_count", xfer_cnt - x0, 1);
    check("ovr_xfer_bit", last_bit, 0);
    check("ovr_valid_dropped", bit_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Random symbols and random gaps against the model, random bit_ready.
    sb_on = 1'b1;
    ready_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < SL; i++) smp[i*8 +: 8] = 8'($urandom_range(255, 0));
      exp_q.push_back(model_entry(smp));
      send_symbol(smp, 0, $urandom_range(2, 0));
      seen = 0;
      while (exp_q.size() > 0 && seen < 60) begin idle(1); seen++; end
      check("rand_drain", exp_q.size(), 0);
      exp_q.delete();
    end
    ready_rand = 1'b0;
    sb_on = 1'b0;
    idle(1);

    // Asynchronous reset mid-symbol with a decision pending.
    bit_ready = 1'b0;
    send_symbol(vecs[1].samples, 0, 0);
    idle(4);
    check("pre_reset_valid", bit_valid, 1);
    for (int i = 0; i < 3; i++) put_sample(i == 0, vecs[0].samples[i*8 +: 8]);
    #3 rst_n = 1'b0;
    #1;
    check("async_bit_valid", bit_valid, 0);
    check("async_bit_out", bit_out, 0);
    check("async_soft_out", soft_out, 0);
    check("async_overrun", overrun, 0);
    check("async_locked", locked, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bit_ready = 1'b1;
    x0 = xfer_cnt;
    seen = 0;
    for (int i = 0; i < SL; i++) begin
      put_sample(1'b0, vecs[0].samples[i*8 +: 8]);
      if (bit_valid) seen = 1;
    end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (bit_valid) seen = 1;
    end
    check("nosync_no_valid", seen, 0);
    check("nosync_no_xfer", xfer_cnt - x0, 0);
    check("nosync_locked", locked, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
